// File: rtl/sub_bytes_engine_if.sv
// Valid/ready bundle for sub_bytes_engine: state in, substituted state out.
// master = producer/consumer side, slave = engine side.
interface sub_bytes_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sub_bytes_engine.sv
// Time-multiplexed AES SubBytes/InvSubBytes over LANES byte lanes per cycle.
// Optional macro SUB_BYTES_PIPE_EN adds a register between lanes and write-back.
module sub_bytes_engine #(
    parameter int LANES = 4,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    sub_bytes_engine_if.slave   bus,
    output logic                busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int LW     = LANES * 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(GROUPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
    if ((1 << CNT_W) < GROUPS) begin : g_bad_cnt
        $error("sub_bytes_engine: CNT_W too narrow for 16/LANES");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic [7:0] rotl(logic [7:0] a, int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] ginv(logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3)
                 ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(logic [7:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [127:0]       work_q, work_d;
    logic               inv_q, inv_d;
    logic [127:0]       out_q, out_d;
    logic [LW-1:0]      lane_in;
    logic [LW-1:0]      lane_out;

`ifdef SUB_BYTES_PIPE_EN
    logic [LW-1:0]      pipe_q, pipe_d;
    logic               pvld_q, pvld_d;
    logic [CNT_W-1:0]   pcnt_q, pcnt_d;
    logic               fed_q, fed_d;
`endif

    always_comb begin
        lane_in = work_q[int'(cnt_q) * LW +: LW];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_out[8*g +: 8] = inv_q ? inv_sbox(lane_in[8*g +: 8])
                                          : fwd_sbox(lane_in[8*g +: 8]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        inv_d   = inv_q;
        out_d   = out_q;
`ifdef SUB_BYTES_PIPE_EN
        pipe_d  = pipe_q;
        pvld_d  = 1'b0;
        pcnt_d  = pcnt_q;
        fed_d   = fed_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_data;
                    inv_d   = bus.in_inv;
                    cnt_d   = '0;
                    state_d = BUSY;
`ifdef SUB_BYTES_PIPE_EN
                    fed_d   = 1'b0;
`endif
                end
            end
            BUSY: begin
`ifdef SUB_BYTES_PIPE_EN
                if (!fed_q) begin
                    pipe_d = lane_out;
                    pvld_d = 1'b1;
                    pcnt_d = cnt_q;
                    if (cnt_q == LAST) fed_d = 1'b1;
                    else               cnt_d = cnt_q + 1'b1;
                end
                if (pvld_q) begin
                    work_d[int'(pcnt_q) * LW +: LW] = pipe_q;
                    if (pcnt_q == LAST) begin
                        cnt_d   = '0;
                        fed_d   = 1'b0;
                        out_d   = work_d;
                        state_d = DONE;
                    end
                end
`else
                work_d[int'(cnt_q) * LW +: LW] = lane_out;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    out_d   = work_d;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            inv_q   <= 1'b0;
            out_q   <= '0;
`ifdef SUB_BYTES_PIPE_EN
            pipe_q  <= '0;
            pvld_q  <= 1'b0;
            pcnt_q  <= '0;
            fed_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            inv_q   <= inv_d;
            out_q   <= out_d;
`ifdef SUB_BYTES_PIPE_EN
            pipe_q  <= pipe_d;
            pvld_q  <= pvld_d;
            pcnt_q  <= pcnt_d;
            fed_q   <= fed_d;
`endif
        end
    end

    // in_ready is gated by rst_n so it reads low for the whole reset pulse.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed + round-trip bench for sub_bytes_engine with a result scoreboard.
// Also runs LANES = 1, 2, 8, 16 instances for per-lane latency checks.
module tb_sub_bytes_engine;

`ifdef SUB_BYTES_PIPE_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    localparam logic [127:0] PV = 128'hFF11_0000_0000_0000_0000_0000_0001_0053;
    localparam logic [127:0] PE = 128'h1682_6363_6363_6363_6363_6363_637C_63ED;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   t_acc = 0;

    logic [127:0] exp_q[$];
    string        tag_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_bytes_engine_if bus ();

    sub_bytes_engine #(.LANES(4), .CNT_W(4)) u4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    logic         aux_valid;
    logic [127:0] aux_data;
    logic         aux_ov[4];
    logic [127:0] aux_od[4];

    for (genvar i = 0; i < 4; i++) begin : g_aux
        localparam int L = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 8 : 16;
        sub_bytes_engine_if ab ();
        logic abusy;
        assign ab.in_valid  = aux_valid;
        assign ab.in_data   = aux_data;
        assign ab.in_inv    = 1'b0;
        assign ab.out_ready = 1'b1;
        assign aux_ov[i]    = ab.out_valid;
        assign aux_od[i]    = ab.out_data;
        sub_bytes_engine #(.LANES(L), .CNT_W(4)) u_aux (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (ab),
            .busy  (abusy)
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic inv,
                        input bit push, input logic [127:0] e,
                        input string tag);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inv   = inv;
        for (int n = 0; n < 50; n++) begin
            acc = bus.in_ready;
            step();
            if (acc) break;
        end
        bus.in_valid = 1'b0;
        t_acc = cyc;
        if (!acc) chk({tag, " accept"}, 128'(acc), 128'(1));
        if (push) begin
            exp_q.push_back(e);
            tag_q.push_back(tag);
        end
    endtask

    task automatic recv(input bit rnd, input bit pop,
                        output logic [127:0] d, output int lat);
        bit got;
        bit held;
        logic [127:0] hold_d;
        logic [127:0] e;
        string t;
        got = 1'b0;
        held = 1'b0;
        hold_d = '0;
        lat = -1;
        d = '0;
        for (int n = 0; n < 300; n++) begin
            if (held) chk("hold valid", 128'(bus.out_valid), 128'(1));
            if (bus.out_valid) begin
                if (lat < 0) lat = cyc - t_acc;
                if (held) chk("hold data", bus.out_data, hold_d);
                d = bus.out_data;
                hold_d = bus.out_data;
                bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                held = !bus.out_ready;
                got = bus.out_ready;
            end
            step();
            if (got) break;
        end
        bus.out_ready = 1'b0;
        if (!got) chk("output timeout", 128'(got), 128'(1));
        if (pop) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard size", 128'(exp_q.size()), 128'(1));
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk(t, d, e);
            end
        end
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] x;
        int lat;
        int alat[4];
        logic [127:0] adat[4];
        int exp_lat[4];
        bit seen;

        exp_lat = '{16, 8, 2, 1};
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_inv = 1'b0;
        bus.out_ready = 1'b0;
        aux_valid = 1'b0;
        aux_data = '0;

        #12;
        chk("rst in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst busy", 128'(busy), 128'(0));
        chk("rst out_data", bus.out_data, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle in_ready", 128'(bus.in_ready), 128'(1));

        send(128'h0, 1'b0, 1'b1, {16{8'h63}}, "fwd zero");
        recv(1'b0, 1'b1, d, lat);
        chk("fwd zero latency", 128'(lat), 128'(4 + PX));

        send({16{8'h63}}, 1'b1, 1'b1, 128'h0, "inv 63");
        recv(1'b0, 1'b1, d, lat);
        send({16{8'hED}}, 1'b1, 1'b1, {16{8'h53}}, "inv ED");
        recv(1'b0, 1'b1, d, lat);

        // Mode/data churn while BUSY, then held backpressure in DONE.
        send(PV, 1'b0, 1'b1, PE, "placement");
        seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            chk("busy in_ready", 128'(bus.in_ready), 128'(0));
            bus.in_valid = 1'b1;
            bus.in_data = {$urandom, $urandom, $urandom, $urandom};
            bus.in_inv = ~bus.in_inv;
            step();
        end
        bus.in_valid = 1'b0;
        chk("placement seen", 128'(seen), 128'(1));
        chk("placement latency", 128'(cyc - t_acc), 128'(4 + PX));
        for (int n = 0; n < 10; n++) begin
            chk("bp out_valid", 128'(bus.out_valid), 128'(1));
            chk("bp out_data", bus.out_data, PE);
            chk("bp in_ready", 128'(bus.in_ready), 128'(0));
            step();
        end
        recv(1'b0, 1'b1, d, lat);

        for (int i = 0; i < 4; i++) begin
            alat[i] = -1;
            adat[i] = '0;
        end
        aux_data = PV;
        aux_valid = 1'b1;
        step();
        aux_valid = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (aux_ov[i] && alat[i] < 0) begin
                    alat[i] = c;
                    adat[i] = aux_od[i];
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lanes%0d latency", exp_lat[i] == 16 ? 1 :
                          exp_lat[i] == 8 ? 2 : exp_lat[i] == 2 ? 8 : 16),
                128'(alat[i]), 128'(exp_lat[i] + PX));
            chk($sformatf("lanes idx%0d data", i), adat[i], PE);
        end

        for (int it = 0; it < 1000; it++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            send(x, 1'b0, 1'b0, '0, "rt fwd");
            recv(1'b1, 1'b0, d, lat);
            send(d, 1'b1, 1'b1, x, "round trip");
            recv(1'b1, 1'b1, d, lat);
        end

        send(128'h0, 1'b0, 1'b1, {16{8'h63}}, "pre reset");
        recv(1'b0, 1'b1, d, lat);
        send(PV, 1'b0, 1'b0, '0, "aborted");
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", 128'(bus.out_valid), 128'(0));
        chk("abort out_data", bus.out_data, 128'h0);
        chk("abort busy", 128'(busy), 128'(0));
        chk("abort in_ready", 128'(bus.in_ready), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step();
        send(PV, 1'b0, 1'b1, PE, "post reset");
        recv(1'b0, 1'b1, d, lat);
        chk("post reset latency", 128'(lat), 128'(4 + PX));

        chk("scoreboard drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
